// File: rtl/bm_dag1_pkg.sv
// Shared definitions for the bm_dag1_pipe add/sub DAG micro-benchmark.
//
// Contents:
//   DEF_WIDTH / DEF_CNT_W   default operand and counter widths
//   dag1_t1_width()         width of the a+b temp for a given config
//   dag1_t23_width()        width of the a-b and b+b temps for a given config
//   dag1_ref()              golden result of (a+b)+(a-b)-(b+b) for a given
//                           width, either wrapped modulo 2^width or clamped
//                           to [0, 2^width-1]
//
// The S1 temp bundle typedef lives in the top module. Its field widths
// depend on WIDTH, and a package typedef cannot see a module parameter, so
// the two width helpers here keep that layout in a single place.

package bm_dag1_pkg;

  localparam int DEF_WIDTH = 2;
  localparam int DEF_CNT_W = 8;

  // The saturating build needs a carry bit on a+b, and a sign bit plus a
  // carry bit on the two other temps.
  function automatic int dag1_t1_width(input int width, input bit sat);
    return sat ? width + 1 : width;
  endfunction

  function automatic int dag1_t23_width(input int width, input bit sat);
    return sat ? width + 2 : width;
  endfunction

  // Reference result. The exact value is 2a-2b. When sat is clear it is
  // wrapped modulo 2^width. When sat is set it is clamped to the unsigned
  // range. width must be in 2..32.
  function automatic logic [31:0] dag1_ref(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input bit          sat,
                                           input int          width = DEF_WIDTH);
    longint exact;
    longint hi;
    exact = 2 * longint'(a) - 2 * longint'(b);
    hi    = (longint'(1) << width) - 1;
    if (sat) begin
      if (exact < 0)       exact = 0;
      else if (exact > hi) exact = hi;
    end else begin
      exact = exact & hi;
    end
    return exact[31:0];
  endfunction

endpackage

// File: rtl/bm_dag1_stage.sv
// Generic valid/ready register slice. It holds one data word and has no
// skid buffer.
//
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-high clear (valid and data go to 0)
//   up_valid    upstream offers up_data
//   up_ready    slice accepts this cycle: empty, or the held word leaves
//   up_data     incoming word (DATA_W bits)
//   down_valid  slice holds a word
//   down_ready  downstream takes the held word this cycle
//   down_data   held word (DATA_W bits)
//
// up_ready depends combinationally on down_ready. When slices are chained,
// a single consumer ready therefore ripples back through the pipeline in
// one cycle.

module bm_dag1_stage #(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [DATA_W-1:0] up_data,
  output logic              down_valid,
  input  logic              down_ready,
  output logic [DATA_W-1:0] down_data
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  assign up_ready = !valid_q || down_ready;

  // A load takes priority over draining. When a word leaves and a new one
  // arrives in the same cycle, the slice stays full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (up_valid && up_ready) begin
      valid_q <= 1'b1;
      data_q  <= up_data;
    end else if (down_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign down_valid = valid_q;
  assign down_data  = data_q;

endmodule

// File: rtl/bm_dag1_pipe.sv
// Two-stage pipelined add/sub DAG:
//   out = (a_in + b_in) + (a_in - b_in) - (b_in + b_in)
// S1 registers the three temps. S2 registers the combined result. Both
// stages use bm_dag1_stage for valid/ready flow control.
//
// Ports:
//   clock      rising-edge clock
//   reset      asynchronous active-high clear of all state
//   in_valid   a_in/b_in hold an operand pair
//   in_ready   pair accepted this cycle (combinational from out_ready)
//   a_in/b_in  unsigned operands, WIDTH bits
//   out_valid  out holds a result
//   out_ready  consumer takes out this cycle
//   out        result, WIDTH bits
//   out_count  consumed results modulo 2^CNT_W
//
// Build option BM_DAG1_SAT_EN:
//   undefined  temps are WIDTH bits and out = (2a - 2b) mod 2^WIDTH
//   defined    temps are widened, and out = 2a - 2b clamped to
//              [0, 2^WIDTH-1]
// Latency and handshake are identical in both builds.

module bm_dag1_pipe
  import bm_dag1_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [CNT_W-1:0] out_count
);

`ifdef BM_DAG1_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam int T1_W  = dag1_t1_width(WIDTH, SAT_EN);
  localparam int T23_W = dag1_t23_width(WIDTH, SAT_EN);

  typedef struct packed {
    logic [T1_W-1:0]  t1;  // a + b
    logic [T23_W-1:0] t2;  // a - b (two's complement when widened)
    logic [T23_W-1:0] t3;  // b + b
  } s1_bundle_t;

  localparam int S1_W = $bits(s1_bundle_t);

  s1_bundle_t       s1_next;
  s1_bundle_t       s1_q;
  logic             s1_valid;
  logic             s2_ready;
  logic [WIDTH-1:0] s2_next;

  // S2 combine. The wrapping build lets the sum overflow naturally. The
  // saturating build works at WIDTH+3 bits: t1+t2 can reach about 3*2^WIDTH
  // before t3 is subtracted, and that value must not wrap.
  function automatic logic [WIDTH-1:0] s2_calc(input s1_bundle_t t);
`ifdef BM_DAG1_SAT_EN
    logic signed [WIDTH+2:0] sum;
    sum = $signed({2'b00, t.t1})
        + $signed({t.t2[T23_W-1], t.t2})
        - $signed({t.t3[T23_W-1], t.t3});
    if (sum < 0)
      return '0;
    else if (sum > $signed({3'b000, {WIDTH{1'b1}}}))
      return '1;
    else
      return sum[WIDTH-1:0];
`else
    return t.t1 + t.t2 - t.t3;
`endif
  endfunction

  always_comb begin
    s1_next = '0;
`ifdef BM_DAG1_SAT_EN
    s1_next.t1 = {1'b0, a_in} + {1'b0, b_in};
    s1_next.t2 = {2'b00, a_in} - {2'b00, b_in};
    s1_next.t3 = {2'b00, b_in} + {2'b00, b_in};
`else
    s1_next.t1 = a_in + b_in;
    s1_next.t2 = a_in - b_in;
    s1_next.t3 = b_in + b_in;
`endif
  end

  bm_dag1_stage #(.DATA_W(S1_W)) u_s1 (
    .clock      (clock),
    .reset      (reset),
    .up_valid   (in_valid),
    .up_ready   (in_ready),
    .up_data    (s1_next),
    .down_valid (s1_valid),
    .down_ready (s2_ready),
    .down_data  (s1_q)
  );

  assign s2_next = s2_calc(s1_q);

  // s2_ready is "S2 may load" (!out_valid || out_ready). It also serves as
  // S1's downstream ready, which makes in_ready = !s1_valid || s2_ready.
  bm_dag1_stage #(.DATA_W(WIDTH)) u_s2 (
    .clock      (clock),
    .reset      (reset),
    .up_valid   (s1_valid),
    .up_ready   (s2_ready),
    .up_data    (s2_next),
    .down_valid (out_valid),
    .down_ready (out_ready),
    .down_data  (out)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      out_count <= '0;
    else if (out_valid && out_ready)
      out_count <= out_count + CNT_W'(1);
  end

  // Cross-check the temp and combine arithmetic against the golden
  // function each time a pair is accepted.
  always_ff @(posedge clock) begin
    if (!reset && in_valid && in_ready)
      assert (s2_calc(s1_next) ==
              WIDTH'(dag1_ref(32'(a_in), 32'(b_in), SAT_EN, WIDTH)));
  end

endmodule

// File: tb/tb_bm_dag1_pipe.sv
// Testbench for bm_dag1_pipe (WIDTH=4, CNT_W=3).

module tb_bm_dag1_pipe;

  localparam int W  = 4;
  localparam int CW = 3;
`ifdef BM_DAG1_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  a_in = '0;
  logic [W-1:0]  b_in = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out;
  logic [CW-1:0] out_count;

  bm_dag1_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_count (out_count)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Result by the arithmetic definition: 2a-2b, either wrapped or clamped.
  function automatic int model(input int a, input int b);
    int d;
    int hi;
    d  = 2 * a - 2 * b;
    hi = (1 << W) - 1;
    if (SAT) return (d < 0) ? 0 : ((d > hi) ? hi : d);
    return ((d % (1 << W)) + (1 << W)) % (1 << W);
  endfunction

  // Transaction-level scoreboard. Each accepted pair carries its expected
  // result and the cycle it was accepted. The oldest pair is presented two
  // cycles after acceptance. At most two pairs are ever in flight.
  typedef struct {
    int res;
    int acc;
  } item_t;

  item_t        q[$];
  int           cyc = 0;
  int           cnt = 0;
  bit           mon_en = 1'b0;
  bit           stalled = 1'b0;
  logic [W-1:0] held;

  always @(negedge clock) begin
    if (reset) begin
      q.delete();
      cnt = 0;
      stalled = 1'b0;
    end else if (mon_en) begin
      chk("out_valid", out_valid, (q.size() > 0 && q[0].acc + 2 <= cyc));
      chk("in_ready", in_ready, !(q.size() == 2 && !out_ready));
      chk("out_count", out_count, cnt % (1 << CW));
      if (stalled) chk("stall_hold", out, held);
      if (out_valid && out_ready) begin
        chk("xfer_has_item", q.size() != 0, 1);
        if (q.size() != 0) begin
          chk("out_data", out, q[0].res);
          void'(q.pop_front());
        end
        cnt++;
      end
      stalled = out_valid && !out_ready;
      held = out;
      if (in_valid && in_ready) q.push_back('{model(int'(a_in), int'(b_in)), cyc});
    end
    cyc++;
  end

  task automatic run_one(input int a, input int b, input int exp, input string tag);
    int k;
    out_ready = 1'b1;
    a_in = W'(a);
    b_in = W'(b);
    in_valid = 1'b1;
    k = 0;
    do begin @(negedge clock); k++; end while (!in_ready && k < 20);
    chk({tag, "_accept"}, in_ready, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    k = 1;
    @(negedge clock);
    while (!out_valid && k < 10) begin @(negedge clock); k++; end
    chk({tag, "_latency"}, k, 2);
    chk({tag, "_value"}, out, exp);
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    int acc;
    int got;
    int nv;
    int v[2];

    // Reset state.
    @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_out_count", out_count, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    mon_en = 1'b1;

    // Basic result and the wrap/saturation corners.
    run_one(5, 3, 4, "basic");
    run_one(3, 5, SAT ? 0 : 12, "neg");
    run_one(15, 0, SAT ? 15 : 14, "high");
    chk("count_three", out_count, 3);

    // Mid-flight reset with both stages full and in_valid held high.
    out_ready = 1'b0;
    in_valid = 1'b1;
    a_in = 4'd9;
    b_in = 4'd2;
    repeat (4) begin @(posedge clock); #1; end
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out", out, 0);
    chk("mid_rst_count", out_count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    repeat (2) begin @(posedge clock); #1; end
    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("post_rst_idle", out_valid, 0);
    end
    @(posedge clock); #1;

    // Streaming: 8 back-to-back pairs. The counter wraps to 0.
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      a_in = W'($urandom_range(0, 15));
      b_in = W'($urandom_range(0, 15));
      in_valid = 1'b1;
      @(negedge clock);
      chk("stream_in_ready", in_ready, 1);
      if (out_valid) nv++;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (out_valid) nv++;
      @(posedge clock); #1;
    end
    chk("stream_results", nv, 8);
    chk("stream_count_wrap", out_count, 0);

    // Backpressure: hold the first result and absorb exactly one more pair.
    out_ready = 1'b0;
    a_in = 4'd7;
    b_in = 4'd2;
    in_valid = 1'b1;
    k = 0;
    do begin @(negedge clock); k++; end while (!in_ready && k < 20);
    @(posedge clock); #1;
    in_valid = 1'b0;
    k = 0;
    do begin @(negedge clock); k++; end while (!out_valid && k < 10);
    chk("bp_first_valid", out_valid, 1);
    @(posedge clock); #1;
    a_in = 4'd3;
    b_in = 4'd1;
    in_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (in_valid && in_ready) acc++;
      @(posedge clock); #1;
      if (acc > 0) in_valid = 1'b0;
    end
    chk("bp_accepted", acc, 1);
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_held", out, 10);
    out_ready = 1'b1;
    got = 0;
    v[0] = -1;
    v[1] = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (out_valid && out_ready) begin
        if (got < 2) v[got] = int'(out);
        got++;
      end
      @(posedge clock); #1;
    end
    chk("bp_release_count", got, 2);
    chk("bp_release_first", v[0], 10);
    chk("bp_release_second", v[1], 4);

    // Simultaneous: both stages full, then in and out transfer every cycle.
    out_ready = 1'b0;
    in_valid = 1'b1;
    k = 0;
    do begin
      a_in = W'($urandom_range(0, 15));
      b_in = W'($urandom_range(0, 15));
      @(negedge clock);
      k++;
      if (in_ready) begin @(posedge clock); #1; end
    end while (in_ready && k < 10);
    chk("sim_filled", in_ready, 0);
    @(posedge clock); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a_in = W'($urandom_range(0, 15));
      b_in = W'($urandom_range(0, 15));
      @(negedge clock);
      chk("sim_in_ready", in_ready, 1);
      chk("sim_out_valid", out_valid, 1);
      @(posedge clock); #1;
    end

    // Randomized traffic checked by the scoreboard.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a_in = W'($urandom_range(0, 15));
      b_in = W'($urandom_range(0, 15));
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) begin @(posedge clock); #1; end
    chk("drain_empty", q.size(), 0);
    chk("drain_out_valid", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
